uart_mem_ctrl: RTL and testbench

Command sequencer between the UART receiver, a single-port byte RAM and the UART transmitter in the memory test design. It parses received bytes as write/read commands, drives one RAM access per command and queues a one-byte response for the transmitter. A per-byte timeout and a saturating error counter keep the link recoverable and observable on the LEDs.

---
 rtl/uart_mem_ctrl.sv | 80 ++++++++
 tb/tb_uart_mem_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: UART command sequencer that turns W/R byte commands into one RAM access each and a one-byte reply
//   i_clk, i_rst (async, active-high)
//   i_rx_valid/i_rx_data        received byte strobe
//   o_mem_addr/o_mem_wdata/o_mem_we/o_mem_re/i_mem_rdata  single-port RAM (rdata one cycle after re)
//   o_tx_valid/o_tx_data/i_tx_ready  response byte handshake
//   o_busy, o_err_cnt           status (saturating error count)
module uart_mem_ctrl #(
  parameter int          TIMEOUT = 4200,
  parameter logic [7:0]  CMD_WR  = 8'h57,
  parameter logic [7:0]  CMD_RD  = 8'h52,
  parameter logic [7:0]  RSP_ACK = 8'h4B,
  parameter logic [7:0]  RSP_NAK = 8'h3F
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_wdata,
  output logic       o_mem_we,
  output logic       o_mem_re,
  input  logic [7:0] i_mem_rdata,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic [7:0] o_err_cnt
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM_WR, MEM_RD, RD_WAIT, TX} state_t;
  state_t state, state_d;
  logic        is_wr, in_cmd, is_cmd, tmo_hit, err_inc;
  logic [12:0] tmo;
  always_comb begin
    in_cmd  = state == ADDR || state == DATA;
    is_cmd  = i_rx_data == CMD_WR || i_rx_data == CMD_RD;
    // an arriving byte always beats the terminal count
    tmo_hit = in_cmd && !i_rx_valid && tmo == 13'(TIMEOUT - 1);
    state_d = state;
    case (state)
      IDLE:    state_d = i_rx_valid ? (is_cmd ? ADDR : TX) : IDLE;
      ADDR:    state_d = i_rx_valid ? (is_wr ? DATA : MEM_RD) : tmo_hit ? IDLE : ADDR;
      DATA:    state_d = i_rx_valid ? MEM_WR : tmo_hit ? IDLE : DATA;
      MEM_WR:  state_d = TX;
      MEM_RD:  state_d = RD_WAIT;
      RD_WAIT: state_d = TX;
      TX:      state_d = i_tx_ready ? IDLE : TX;
      default: state_d = IDLE;
    endcase
    // sources are exclusive by state, so one increment covers any cycle
    err_inc = (state == IDLE && i_rx_valid && !is_cmd) || tmo_hit ||
              (i_rx_valid && !in_cmd && state != IDLE);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      is_wr       <= 1'b0;
      tmo         <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_tx_data   <= '0;
      o_err_cnt   <= '0;
    end else begin
      state <= state_d;
      tmo   <= (state_d != state || i_rx_valid || !in_cmd) ? '0 : tmo + 13'd1;
      if (state == IDLE && i_rx_valid) begin
        is_wr <= i_rx_data == CMD_WR;
        if (!is_cmd) o_tx_data <= RSP_NAK;
      end
      if (state == ADDR && i_rx_valid) o_mem_addr <= i_rx_data;
      if (state == DATA && i_rx_valid) o_mem_wdata <= i_rx_data;
      if (state == MEM_WR) o_tx_data <= RSP_ACK;
      if (state == RD_WAIT) o_tx_data <= i_mem_rdata;
      if (err_inc && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
  assign o_mem_we   = state == MEM_WR;
  assign o_mem_re   = state == MEM_RD;
  assign o_tx_valid = state == TX;
  assign o_busy     = state != IDLE;
endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: scoreboard bench for uart_mem_ctrl with a behavioural RAM
module tb_uart_mem_ctrl;
  localparam int TIMEOUT = 4200;
  logic       i_clk = 1'b0, i_rst = 1'b1;
  logic       i_rx_valid = 1'b0, i_tx_ready = 1'b1;
  logic [7:0] i_rx_data = '0, i_mem_rdata = '0;
  logic [7:0] o_mem_addr, o_mem_wdata, o_tx_data, o_err_cnt;
  logic       o_mem_we, o_mem_re, o_tx_valid, o_busy;
  logic [7:0] ram [256];
  logic [7:0] exp_q [$];
  int tests = 0, fails = 0, we_cnt = 0, re_cnt = 0, tx_cnt = 0;

  uart_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
    .i_mem_rdata(i_mem_rdata), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;

  always @(posedge i_clk) begin
    if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
    if (o_mem_re) i_mem_rdata <= ram[o_mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) if (!i_rst) begin
    if (o_mem_we) we_cnt++;
    if (o_mem_re) re_cnt++;
    if (o_tx_valid && i_tx_ready) begin
      tx_cnt++;
      chk("tx_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("tx_data", o_tx_data, exp_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge i_clk); #1 i_rx_valid = 1'b1; i_rx_data = b;
    @(posedge i_clk); #1 i_rx_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!o_tx_valid && n < 20) begin @(negedge i_clk); n++; end
    chk(tag, 32'(o_tx_valid), 1);
  endtask

  task automatic settle();
    int n = 0;
    while (o_busy && n < 20) begin @(negedge i_clk); n++; end
    chk("settle_idle", 32'(o_busy), 0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, tx0;
    logic stable;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_err", o_err_cnt, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_txdata", o_tx_data, 0);
    chk("rst_ctrl", {o_mem_we, o_mem_re, o_tx_valid}, 0);

    // write 10 <- A5, check cycle-exact pulses
    send(8'h57); send(8'h10); exp_q.push_back(8'h4B); send(8'hA5);
    @(negedge i_clk);
    chk("wr_we", 32'(o_mem_we), 1);
    chk("wr_addr", o_mem_addr, 8'h10);
    chk("wr_wdata", o_mem_wdata, 8'hA5);
    chk("wr_txv_early", 32'(o_tx_valid), 0);
    @(negedge i_clk);
    chk("wr_txv", 32'(o_tx_valid), 1);
    settle();
    chk("wr_we_cnt", we_cnt, 1);

    // read it back: re at T+1, RD_WAIT at T+2, tx at T+3
    send(8'h52); exp_q.push_back(8'hA5); send(8'h10);
    @(negedge i_clk);
    chk("rd_re", 32'(o_mem_re), 1);
    chk("rd_we", 32'(o_mem_we), 0);
    @(negedge i_clk);
    chk("rd_wait_txv", 32'(o_tx_valid), 0);
    @(negedge i_clk);
    chk("rd_txv", 32'(o_tx_valid), 1);
    settle();
    chk("hold_addr", o_mem_addr, 8'h10);
    chk("hold_wdata", o_mem_wdata, 8'hA5);

    // unknown command
    exp_q.push_back(8'h3F); send(8'h00);
    @(negedge i_clk);
    chk("nak_txv", 32'(o_tx_valid), 1);
    chk("nak_data", o_tx_data, 8'h3F);
    chk("nak_err", o_err_cnt, 1);
    settle();
    chk("nak_we_re", we_cnt + re_cnt, 2);

    // timeout in DATA
    we0 = we_cnt; tx0 = tx_cnt;
    send(8'h57); send(8'h20);
    repeat (TIMEOUT - 1) @(posedge i_clk);
    @(negedge i_clk);
    chk("tmo_still_busy", 32'(o_busy), 1);
    @(negedge i_clk);
    chk("tmo_idle", 32'(o_busy), 0);
    chk("tmo_err", o_err_cnt, 2);
    chk("tmo_no_we", we_cnt, we0);
    chk("tmo_no_tx", tx_cnt, tx0);
    send(8'h52); exp_q.push_back(8'h20 ^ 8'h5A); send(8'h20);
    wait_valid("tmo_next_rd");
    settle();

    // backpressure with a dropped byte
    #1 i_tx_ready = 1'b0;
    send(8'h52); exp_q.push_back(8'hA5); send(8'h10);
    wait_valid("bp_valid");
    stable = 1'b1;
    repeat (20) begin @(negedge i_clk); if (!o_tx_valid || o_tx_data !== 8'hA5) stable = 1'b0; end
    send(8'h33);
    repeat (28) begin @(negedge i_clk); if (!o_tx_valid || o_tx_data !== 8'hA5) stable = 1'b0; end
    chk("bp_stable", 32'(stable), 1);
    chk("bp_drop_err", o_err_cnt, 3);
    @(posedge i_clk); #1 i_tx_ready = 1'b1;
    settle();

    // reset mid-write
    we0 = we_cnt;
    send(8'h57); send(8'h30);
    @(negedge i_clk); i_rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_err", o_err_cnt, 0);
    chk("mrst_addr", o_mem_addr, 0);
    chk("mrst_wdata", o_mem_wdata, 0);
    chk("mrst_ctrl", {o_mem_we, o_mem_re, o_tx_valid}, 0);
    @(negedge i_clk); i_rst = 1'b0;
    chk("mrst_no_we", we_cnt, we0);
    send(8'h57); send(8'h40); exp_q.push_back(8'h4B); send(8'hC3);
    settle();
    chk("mrst_we_cnt", we_cnt, we0 + 1);
    send(8'h52); exp_q.push_back(8'hC3); send(8'h40);
    settle();

    // saturation
    for (int i = 0; i < 300; i++) begin exp_q.push_back(8'h3F); send(8'h00); end
    settle();
    chk("sat_err", o_err_cnt, 8'hFF);
    repeat (5) @(negedge i_clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("re_total", re_cnt, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
